// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with sof framing and HUNT/SYNC lock tracking.
// Words are staged in shadow registers; the four outputs update only when a frame completes.
module tdm_demux4 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sof,
  output logic [W-1:0] dout_a,
  output logic [W-1:0] dout_b,
  output logic [W-1:0] dout_c,
  output logic [W-1:0] dout_d,
  output logic         frame_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err,
  output logic [7:0]   frame_cnt
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] SYNC = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [W-1:0] sh0_q, sh0_d;
  logic [W-1:0] sh1_q, sh1_d;
  logic [W-1:0] sh2_q, sh2_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;
  logic [W-1:0] d_q, d_d;
  logic         fv_q, fv_d;
  logic         err_q, err_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         hunt;

  assign hunt = (state_q == HUNT);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (din_valid) begin
      unique case (1'b1)
        sof: begin
          // sof mid-frame drops the partial frame and restarts at slot 0
          err_d   = !hunt && (slot_q != 2'd0);
          sh0_d   = din;
          slot_d  = 2'd1;
          state_d = SYNC;
        end
        (!sof && hunt): begin
        end
        (!sof && !hunt && slot_q == 2'd0): begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
        default: begin
          slot_d = slot_q + 2'd1;
          case (slot_q)
            2'd1: sh1_d = din;
            2'd2: sh2_d = din;
            2'd3: begin
              a_d   = sh0_q;
              b_d   = sh1_q;
              c_d   = sh2_q;
              d_d   = din;
              fv_d  = 1'b1;
              cnt_d = cnt_q + 8'd1;
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_a      = a_q;
  assign dout_b      = b_q;
  assign dout_c      = c_q;
  assign dout_d      = d_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign locked      = (state_q == SYNC);
  assign sync_err    = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: framing, gaps, resync, loss of lock,
// frame counter wrap and asynchronous reset mid-frame.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sof;
  logic [7:0] dout_a, dout_b, dout_c, dout_d;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
  logic [7:0] frame_cnt;

  int checks;
  int failures;

  tdm_demux4 #(.W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .dout_a      (dout_a),
    .dout_b      (dout_b),
    .dout_c      (dout_c),
    .dout_d      (dout_d),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic s);
    @(negedge clk);
    din       = d;
    sof       = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    put(a, 1'b1);
    put(b, 1'b0);
    put(c, 1'b0);
    put(d, 1'b0);
  endtask

  task automatic gap(input int n, input logic [1:0] exp_slot);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("gap_slot", {30'd0, slot}, {30'd0, exp_slot});
      chk("gap_fv", {31'd0, frame_valid}, 32'd0);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d);
    chk(tag, {dout_a, dout_b, dout_c, dout_d}, {a, b, c, d});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    sof       = 1'b0;
    #12;
    outs("rst_dout", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst_misc", {frame_valid, sync_err, locked, slot, frame_cnt},
        {5'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;

    // words before the first sof are dropped
    put(8'h01, 1'b0);
    put(8'h02, 1'b0);
    chk("pre_sof", {frame_valid, sync_err, locked, slot}, 5'b0);
    outs("pre_dout", 8'h00, 8'h00, 8'h00, 8'h00);

    // back-to-back frame
    put(8'h11, 1'b1);
    chk("lock_slot", {locked, slot}, {1'b1, 2'd1});
    put(8'h22, 1'b0);
    put(8'h33, 1'b0);
    chk("partial_hidden", {frame_valid, dout_a}, {1'b0, 8'h00});
    put(8'h44, 1'b0);
    outs("f1_dout", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("f1_flags", {frame_valid, sync_err, locked, frame_cnt},
        {3'b101, 8'd1});
    gap(1, 2'd0);

    // same frame with 3-cycle gaps between words
    put(8'h11, 1'b1);
    gap(3, 2'd1);
    put(8'h22, 1'b0);
    gap(3, 2'd2);
    put(8'h33, 1'b0);
    gap(3, 2'd3);
    put(8'h44, 1'b0);
    outs("f2_dout", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("f2_flags", {frame_valid, frame_cnt}, {1'b1, 8'd2});

    // sof in slot 2 forces a resync
    put(8'h55, 1'b1);
    put(8'h66, 1'b0);
    chk("pre_resync_fv", {31'd0, frame_valid}, 32'd0);
    put(8'h77, 1'b1);
    chk("resync", {frame_valid, sync_err, locked, slot, frame_cnt},
        {3'b011, 2'd1, 8'd2});
    put(8'h88, 1'b0);
    chk("resync_clear", {frame_valid, sync_err}, 2'b00);
    put(8'h99, 1'b0);
    put(8'hAA, 1'b0);
    outs("f3_dout", 8'h77, 8'h88, 8'h99, 8'hAA);
    chk("f3_flags", {frame_valid, sync_err, frame_cnt}, {2'b10, 8'd3});

    // slot-0 word without sof drops lock
    put(8'h12, 1'b0);
    chk("lose_lock", {frame_valid, sync_err, locked, slot},
        {3'b010, 2'd0});
    put(8'h13, 1'b0);
    put(8'h14, 1'b0);
    chk("hunt_ignore", {sync_err, locked, slot, frame_cnt},
        {2'b00, 2'd0, 8'd3});
    outs("hunt_hold", 8'h77, 8'h88, 8'h99, 8'hAA);
    frame(8'h21, 8'h22, 8'h23, 8'h24);
    outs("relock_dout", 8'h21, 8'h22, 8'h23, 8'h24);
    chk("relock_flags", {frame_valid, locked, frame_cnt}, {2'b11, 8'd4});

    // 252 more frames brings the count to 256, wrapping to 0
    for (int i = 0; i < 252; i++) begin
      frame(8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3));
    end
    chk("wrap_cnt", {frame_valid, frame_cnt}, {1'b1, 8'd0});
    outs("wrap_dout", 8'hFB, 8'hFC, 8'hFD, 8'hFE);

    // asynchronous reset mid-frame
    put(8'h31, 1'b1);
    put(8'h32, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    outs("arst_dout", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("arst_misc", {frame_valid, sync_err, locked, slot, frame_cnt},
        {5'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    put(8'h33, 1'b0);
    put(8'h34, 1'b0);
    chk("post_rst", {frame_valid, sync_err, locked, slot}, 5'b0);
    outs("post_rst_dout", 8'h00, 8'h00, 8'h00, 8'h00);
    frame(8'h41, 8'h42, 8'h43, 8'h44);
    outs("f_new_dout", 8'h41, 8'h42, 8'h43, 8'h44);
    chk("f_new_flags", {frame_valid, frame_cnt}, {1'b1, 8'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
